// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin stream arbiter.
// Provides the output-register FSM states, default sizing and the requester-index width helper.
package stream_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: searches last+1, last+2, ... modulo NUM_REQ
// and returns the first valid requester plus a flag saying whether any was found.
module rr_pick
    import stream_arb_pkg::*;
#(
    parameter int  NUM_REQ = NUM_REQ_DEF,
    localparam int IW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [IW-1:0]      sel,
    output logic               any
);

    // Walk the offsets from farthest to nearest so the nearest valid one wins.
    always_comb begin
        sel = last;
        any = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last) + k) % NUM_REQ]) begin
                sel = IW'((int'(last) + k) % NUM_REQ);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging NUM_REQ valid/ready streams into one registered output stream.
// Optional burst locking (req_last/out_last) is enabled by defining STREAM_RR_ARBITER_BURST_LOCK_EN.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int  NUM_REQ = NUM_REQ_DEF,
    parameter int  DATA_W  = DATA_W_DEF,
    localparam int IW      = idx_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef STREAM_RR_ARBITER_BURST_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_last,
    output logic                      out_last,
`endif
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready,
    output logic [IW-1:0]             grant_id,
    output logic                      busy
);

    arb_state_t        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [IW-1:0]     last_q, last_d;

    logic [DATA_W-1:0] req_data_arr [NUM_REQ];
    logic [IW-1:0]     pick_sel;
    logic              pick_any;
    logic [IW-1:0]     sel;
    logic              sel_valid;
    logic              can_load;
    logic              handshake;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req  (req_valid),
        .last (last_q),
        .sel  (pick_sel),
        .any  (pick_any)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
            assign req_ready[gi]    = handshake & (sel == IW'(gi));
        end
    endgenerate

`ifdef STREAM_RR_ARBITER_BURST_LOCK_EN
    logic lock_q, lock_d;
    logic out_last_q, out_last_d;

    // The lock owner is always the last granted requester, so last_q doubles as the lock id.
    assign sel       = lock_q ? last_q : pick_sel;
    assign sel_valid = lock_q ? req_valid[last_q] : pick_any;
    assign busy      = out_valid | lock_q;
    assign out_last  = out_last_q;
`else
    assign sel       = pick_sel;
    assign sel_valid = pick_any;
    assign busy      = out_valid;
`endif

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign grant_id  = grant_q;
    assign can_load  = !out_valid | out_ready;
    assign handshake = rst & can_load & sel_valid;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        grant_d = grant_q;
        last_d  = last_q;
`ifdef STREAM_RR_ARBITER_BURST_LOCK_EN
        lock_d     = lock_q;
        out_last_d = out_last_q;
`endif
        if (handshake) begin
            state_d = FULL;
            data_d  = req_data_arr[sel];
            grant_d = sel;
            last_d  = sel;
`ifdef STREAM_RR_ARBITER_BURST_LOCK_EN
            lock_d     = !req_last[sel];
            out_last_d = req_last[sel];
`endif
        end else if (out_valid && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            grant_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

`ifdef STREAM_RR_ARBITER_BURST_LOCK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_q     <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            out_last_q <= out_last_d;
        end
    end
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: directed phases plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready;
    logic [IW-1:0]  grant_id;
    logic           busy;
`ifdef STREAM_RR_ARBITER_BURST_LOCK_EN
    logic [N-1:0]   req_last;
    logic           out_last;
`endif

    always #5 clk = ~clk;

    stream_rr_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
`ifdef STREAM_RR_ARBITER_BURST_LOCK_EN
        .req_last  (req_last),
        .out_last  (out_last),
`endif
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: contents of the output slot, the round-robin pointer and the burst lock.
    bit       m_valid;
    bit [W-1:0] m_data;
    int       m_id;
    int       m_last;
    bit       m_lock;
    bit       m_olast;

    int         acc_id[$];
    bit [W-1:0] acc_data[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_last  = N - 1;
        m_lock  = 1'b0;
        m_olast = 1'b0;
    endfunction

    function automatic int pick();
        if (m_lock) return req_valid[m_last] ? m_last : -1;
        for (int k = 1; k <= N; k++) begin
            if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    // One clock: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        int     s;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        s = pick();
        exp_ready = '0;
        if (rst && (!m_valid || out_ready) && s >= 0) exp_ready[s] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data",  32'(out_data),  32'(m_data));
        check("grant_id",  32'(grant_id),  32'(m_id));
        check("busy",      32'(busy),      32'(m_valid || m_lock));
`ifdef STREAM_RR_ARBITER_BURST_LOCK_EN
        check("out_last",  32'(out_last),  32'(m_olast));
`endif
        if (rst && out_valid && out_ready) begin
            acc_id.push_back(int'(grant_id));
            acc_data.push_back(out_data);
        end
        if (!rst) begin
            model_reset();
        end else if (exp_ready != '0) begin
            m_valid = 1'b1;
            m_data  = req_data[s*W +: W];
            m_id    = s;
            m_last  = s;
`ifdef STREAM_RR_ARBITER_BURST_LOCK_EN
            m_lock  = !req_last[s];
            m_olast = req_last[s];
`endif
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_data_inc();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(8'h10 + i);
    endtask

    initial begin
        int exp_rr [5] = '{0, 1, 2, 3, 0};
        model_reset();
        rst       = 1'b0;
        req_valid = '1;
        out_ready = 1'b1;
        set_data_inc();
`ifdef STREAM_RR_ARBITER_BURST_LOCK_EN
        req_last  = '1;
`endif
        @(posedge clk);
        #1;

        // Reset held with every requester asking
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst_ready", 32'(req_ready), 32'd0);
        end
        rst = 1'b1;

        // Round-robin with all requesters valid
        acc_id.delete();
        acc_data.delete();
        for (int i = 0; i < 6; i++) cycle();
        check("rr_count", 32'(acc_id.size()), 32'd5);
        for (int i = 0; i < 5 && i < acc_id.size(); i++) begin
            check("rr_id",   32'(acc_id[i]),   32'(exp_rr[i]));
            check("rr_data", 32'(acc_data[i]), 32'(8'h10 + exp_rr[i]));
        end

        // Backpressure while holding A5
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'hA5;
        cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_hold", 32'(out_data), 32'hA5);
        end
        set_data_inc();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Sparse requests: only 1 and 3
        req_valid = 4'b1010;
        acc_id.delete();
        for (int i = 0; i < 6; i++) cycle();
        check("sparse_count", 32'(acc_id.size() >= 4), 32'd1);
        for (int i = 0; i + 1 < acc_id.size(); i++) begin
            check("sparse_set", 32'(acc_id[i] == 1 || acc_id[i] == 3), 32'd1);
            check("sparse_alt", 32'(acc_id[i] != acc_id[i+1]), 32'd1);
        end

        // Reset while FULL
        req_valid = '1;
        out_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        acc_id.delete();
        for (int i = 0; i < 2; i++) cycle();
        check("mid_rst_first", 32'(acc_id.size() > 0 ? acc_id[0] : -1), 32'd0);

`ifdef STREAM_RR_ARBITER_BURST_LOCK_EN
        // Requester 2 sends a three-beat burst while requester 0 also waits
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        acc_id.delete();
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        cycle();
        req_valid = 4'b0101;
        cycle();
        req_last  = 4'b0100;
        cycle();
        req_valid = 4'b0001;
        req_last  = 4'b1111;
        cycle();
        req_valid = 4'b0000;
        cycle();
        check("burst_count", 32'(acc_id.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_id.size(); i++)
            check("burst_id", 32'(acc_id[i]), (i < 3) ? 32'd2 : 32'd0);
`endif

        // Randomized traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 59) != 0);
            req_valid = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
`ifdef STREAM_RR_ARBITER_BURST_LOCK_EN
            req_last  = N'($urandom);
`endif
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

- Shares the single slave datapath between `NUM_REQ` master-side requesters using round-robin arbitration.
- Each requester presents a valid/ready/data stream. The block accepts at most one beat per cycle, registers it, and presents it to the slave on one valid/ready/data output. It also reports which requester owns the beat.
- Sits between the master instances and the slave, in place of the direct master-to-slave connection in `top`.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters; legal range 2..16.
- `DATA_W`, 8, data width per beat.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  per-requester beat valid.
- `req_data`  in  `NUM_REQ*DATA_W`  requester *i* data in bits [*i*·`DATA_W` +: `DATA_W`].
- `req_ready`  out  `NUM_REQ`  per-requester accept; at most one bit high.
- `out_valid`  out  1  beat valid toward the slave.
- `out_data`  out  `DATA_W`  registered beat data.
- `out_ready`  in  1  slave accept.
- `grant_id`  out  `$clog2(NUM_REQ)`  index of the requester that owns `out_data`.
- `busy`  out  1  high while `out_valid` is high or a burst lock is held.

## Operation
- Two-state FSM:
  - **EMPTY**: output register free.
  - **FULL**: `out_valid`=1, beat held.
- **can_load** = (state==EMPTY) | (out_ready & out_valid).
- Round-robin pointer `last`:
  - Search order is `last`+1, `last`+2, … wrapping modulo `NUM_REQ`.
  - The first requester with `req_valid` high is `sel`.
- `req_ready[sel]` = can_load & `req_valid[sel]`. All other `req_ready` bits are 0. `req_ready` is combinational from registered state and the current inputs.
- On a handshake (`req_valid[sel]` & `req_ready[sel]`):
  - `out_data` ← `req_data[sel]`, `grant_id` ← `sel`, `last` ← `sel`.
  - State goes to FULL.
- If out_ready & out_valid and no new handshake occurs, state goes to EMPTY. `out_data` and `grant_id` keep their last value.
- While FULL & !out_ready:
  - `out_data` and `grant_id` are stable.
  - No requester is readied.
  - `last` is frozen.
- Requesters keep `req_valid` and their data stable until readied. The arbiter does not depend on this rule; a withdrawn request simply loses its turn.
- Reset mid-operation: a held beat is discarded and every requester loses its pending grant.

## Timing
Reset values:
- `out_valid`=0, `out_data`=0, `grant_id`=0, `busy`=0, state=EMPTY.
- `last`=`NUM_REQ`-1, so requester 0 wins first.
- `req_ready`=0 whenever `rst`=0.

Latency and throughput:
- Handshake in cycle *n* gives `out_valid`=1 with the data in cycle *n*+1.
- Throughput is 1 beat/cycle when `out_ready` is held high; back-to-back beats have no bubble.

Fairness:
- With all requesters active and `out_ready`=1, grants rotate 0,1,…,`NUM_REQ`-1,0,…
- No requester waits more than `NUM_REQ`-1 accepted beats.

Edge cases:
- A single active requester is granted every cycle.
- If `out_ready` rises in the same cycle a new request arrives, the drain and the load happen together and state stays FULL.

## Configuration
Macro: `STREAM_RR_ARBITER_BURST_LOCK_EN`.

- **Defined:**
  - Adds input `req_last` [`NUM_REQ`] and output `out_last` [1]. `out_last` is registered alongside `out_data` and resets to 0.
  - A lock register is set when a handshake has `req_last[sel]`=0.
  - While locked, `sel` is forced to the locked requester; other requesters are not readied even if it idles.
  - The lock clears on the handshake whose `req_last`=1.
  - `busy` includes the lock. Reset clears the lock.
- **Undefined:** arbitration happens on every beat; no `req_last` or `out_last` ports exist.

## Structure
- Package `stream_arb_pkg` holds:
  - the FSM state enum (EMPTY, FULL);
  - the default `NUM_REQ` and `DATA_W` constants;
  - the requester-index width helper (`$clog2`).
- Sub-module `rr_pick`: purely combinational. It takes the request vector and `last` and produces `sel` plus an any-valid flag. The top module holds the FSM, pointer, output register and lock.

## Test plan
- **Reset:** assert `rst`=0 for 3 cycles with all `req_valid` high. Expect `req_ready`=0 and `out_valid`=0. After release, the first grant is requester 0 and its data appears the next cycle.
- **Round-robin:** 4 requesters always valid with data 8'h10+i, `out_ready`=1. Expect `out_data` sequence 10,11,12,13,10 with `grant_id` 0,1,2,3,0 and no bubbles.
- **Backpressure:** hold `out_ready`=0 for 5 cycles while FULL with 8'hA5. Expect `out_data` stable at A5, `req_ready`=0 throughout, then the next beat one cycle after `out_ready` rises.
- **Sparse requests:** only requesters 1 and 3 valid. Expect grants alternating 1,3,1,3; requesters 0 and 2 are never readied.
- **Reset mid-operation:** pulse `rst` low while FULL. Expect `out_valid` to drop the next cycle, the beat to be lost, and `last` back to 3.
- **Burst lock (macro defined):** requester 2 sends a 3-beat burst (`req_last` only on beat 3) while requester 0 is valid. Expect `grant_id` 2,2,2 then 0.
